// File: rtl/de3d_tc_pkg.sv
// Shared definitions for the texture-cache tag controller: FSM states,
// bank encodings, geometry constants and small arithmetic helpers.
package de3d_tc_pkg;

  localparam int TAG_W_DEF  = 13;
  localparam int NUM_BANKS  = 4;
  localparam int IDX_W      = 5;
  localparam int BANK_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMP  = 3'd1,
    ST_REQ  = 3'd2,
    ST_FILL = 3'd3,
    ST_OUT  = 3'd4
  } tc_state_e;

  typedef enum logic [1:0] {
    BANK_EE = 2'd0,
    BANK_EO = 2'd1,
    BANK_OE = 2'd2,
    BANK_OO = 2'd3
  } tc_bank_e;

  // Lowest outstanding bank wins: ee before eo before oe before oo.
  function automatic tc_bank_e lowest_bank(input logic [NUM_BANKS-1:0] v);
    if (v[0])      return BANK_EE;
    else if (v[1]) return BANK_EO;
    else if (v[2]) return BANK_OE;
    else           return BANK_OO;
  endfunction

  function automatic logic [2:0] count_ones(input logic [NUM_BANKS-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // 16-bit counter add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/de3d_tc_tag_bank.sv
// One 32-entry tag bank: tag storage, per-entry valid bits, asynchronous
// read port, single write port and a one-cycle invalidate-all.
module de3d_tc_tag_bank
  import de3d_tc_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             de_clk,
  input  logic             de_rst,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [TAG_W-1:0]      tag_mem [BANK_DEPTH];
  logic [BANK_DEPTH-1:0] valid;

  // Valid bits: cleared by reset or flush, set by a fill write.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge de_clk) begin
    if (de_rst || clr_all) valid <= '0;
    else if (wr_en)        valid[wr_idx] <= 1'b1;
  end

  // Tag storage written on fill.
  // NOTE: tag entries are deliberately not reset; the valid vector alone decides whether they are meaningful.
  always_ff @(posedge de_clk) begin
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/de3d_tc_tag_ctl.sv
// Texture-cache tag lookup and miss sequencer. Compares a four-bank request
// against the tag banks, issues one memory fill per missing bank, then
// presents the completed lookup downstream while stalling upstream.
// Optional build macro DE3D_TC_STATS_EN adds saturating hit/miss counters;
// without it stat_hit/stat_miss are tied to zero.
module de3d_tc_tag_ctl
  import de3d_tc_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             de_clk,
  input  logic             de_rst,
  input  logic             push_uv_dd,
  input  logic             current_clip_dd,
  input  logic [4:0]       ee_tag_adr_rd,
  input  logic [4:0]       eo_tag_adr_rd,
  input  logic [4:0]       oe_tag_adr_rd,
  input  logic [4:0]       oo_tag_adr_rd,
  input  logic [TAG_W-1:0] ee_tag_in,
  input  logic [TAG_W-1:0] eo_tag_in,
  input  logic [TAG_W-1:0] oe_tag_in,
  input  logic [TAG_W-1:0] oo_tag_in,
  input  logic             tc_flush,
  output logic             tc_busy,
  output logic             mc_req,
  output logic [1:0]       mc_bank,
  output logic [4:0]       mc_idx,
  output logic [TAG_W-1:0] mc_tag,
  input  logic             mc_ack,
  input  logic             mc_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_clip,
  output logic [3:0]       out_miss,
  output logic             ovf_err,
  output logic [15:0]      stat_hit,
  output logic [15:0]      stat_miss
);

  tc_state_e state, state_nxt;

  logic [IDX_W-1:0]     idx_in [NUM_BANKS];
  logic [TAG_W-1:0]     tag_in [NUM_BANKS];
  logic [IDX_W-1:0]     idx_r  [NUM_BANKS];
  logic [TAG_W-1:0]     tag_r  [NUM_BANKS];
  logic [TAG_W-1:0]     rd_tag [NUM_BANKS];
  logic [NUM_BANKS-1:0] rd_valid;
  logic [NUM_BANKS-1:0] hit;
  logic [NUM_BANKS-1:0] miss_vec;
  logic [NUM_BANKS-1:0] work_r;
  logic [NUM_BANKS-1:0] cur_onehot;
  logic [1:0]           cur_bank;
  logic                 clip_r;
  logic                 flush_pend;
  logic                 clr_all;
  logic                 fill_done;

  assign idx_in[0] = ee_tag_adr_rd;
  assign idx_in[1] = eo_tag_adr_rd;
  assign idx_in[2] = oe_tag_adr_rd;
  assign idx_in[3] = oo_tag_adr_rd;
  assign tag_in[0] = ee_tag_in;
  assign tag_in[1] = eo_tag_in;
  assign tag_in[2] = oe_tag_in;
  assign tag_in[3] = oo_tag_in;

  assign cur_bank   = lowest_bank(work_r);
  assign cur_onehot = 4'b0001 << cur_bank;
  assign fill_done  = (state == ST_FILL) && mc_done;
  // Flush takes effect only on an idle cycle that is not also taking a request.
  assign clr_all    = (state == ST_IDLE) && !push_uv_dd && (tc_flush || flush_pend);
  assign miss_vec   = clip_r ? '0 : ~hit;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    de3d_tc_tag_bank #(.TAG_W(TAG_W)) u_bank (
      .de_clk   (de_clk),
      .de_rst   (de_rst),
      .clr_all  (clr_all),
      .rd_idx   (idx_r[b]),
      .rd_tag   (rd_tag[b]),
      .rd_valid (rd_valid[b]),
      .wr_en    (fill_done && (cur_bank == 2'(b))),
      .wr_idx   (idx_r[b]),
      .wr_tag   (tag_r[b])
    );
    assign hit[b] = rd_valid[b] && (rd_tag[b] == tag_r[b]);
  end

  // FSM state register.
  always_ff @(posedge de_clk) begin
    if (de_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (push_uv_dd) state_nxt = ST_CMP;
      ST_CMP:  state_nxt = (miss_vec == '0) ? ST_OUT : ST_REQ;
      ST_REQ:  if (mc_ack) state_nxt = ST_FILL;
      ST_FILL: if (mc_done) state_nxt = ((work_r & ~cur_onehot) != '0) ? ST_REQ : ST_OUT;
      ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, miss bookkeeping, pending flush and overflow flag.
  always_ff @(posedge de_clk) begin
    if (de_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        idx_r[b] <= '0;
        tag_r[b] <= '0;
      end
      clip_r     <= 1'b0;
      out_miss   <= '0;
      work_r     <= '0;
      flush_pend <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (state == ST_IDLE && push_uv_dd) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          idx_r[b] <= idx_in[b];
          tag_r[b] <= tag_in[b];
        end
        clip_r <= current_clip_dd;
      end
      if (state == ST_CMP) begin
        out_miss <= miss_vec;
        work_r   <= miss_vec;
      end
      if (fill_done) work_r <= work_r & ~cur_onehot;
      if (clr_all)       flush_pend <= 1'b0;
      else if (tc_flush) flush_pend <= 1'b1;
      if (push_uv_dd && state != ST_IDLE) ovf_err <= 1'b1;
    end
  end

  assign tc_busy   = (state != ST_IDLE);
  assign mc_req    = (state == ST_REQ);
  assign mc_bank   = mc_req ? cur_bank : 2'd0;
  assign mc_idx    = mc_req ? idx_r[cur_bank] : '0;
  assign mc_tag    = mc_req ? tag_r[cur_bank] : '0;
  assign out_valid = (state == ST_OUT);
  assign out_clip  = clip_r;

`ifdef DE3D_TC_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  // Hit/miss bank counts of each non-clipped lookup, saturating.
  always_ff @(posedge de_clk) begin
    if (de_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_CMP && !clip_r) begin
      hit_cnt  <= sat_add(hit_cnt, count_ones(hit));
      miss_cnt <= sat_add(miss_cnt, count_ones(~hit));
    end
  end

  assign stat_hit  = hit_cnt;
  assign stat_miss = miss_cnt;
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_de3d_tc_tag_ctl.sv
// Self-checking bench for de3d_tc_tag_ctl: directed scenarios followed by
// randomized lookups, compared every cycle against a behavioural cache model.
module tb_de3d_tc_tag_ctl;
  import de3d_tc_pkg::*;

  localparam int TW = 13;

  logic          de_clk, de_rst, push_uv_dd, current_clip_dd, tc_flush;
  logic [4:0]    ee_adr, eo_adr, oe_adr, oo_adr;
  logic [TW-1:0] ee_tg, eo_tg, oe_tg, oo_tg;
  logic          tc_busy, mc_req, mc_ack, mc_done, out_valid, out_ready, out_clip, ovf_err;
  logic [1:0]    mc_bank;
  logic [4:0]    mc_idx;
  logic [TW-1:0] mc_tag;
  logic [3:0]    out_miss;
  logic [15:0]   stat_hit, stat_miss;

  de3d_tc_tag_ctl #(.TAG_W(TW)) dut (
    .de_clk(de_clk), .de_rst(de_rst), .push_uv_dd(push_uv_dd), .current_clip_dd(current_clip_dd),
    .ee_tag_adr_rd(ee_adr), .eo_tag_adr_rd(eo_adr), .oe_tag_adr_rd(oe_adr), .oo_tag_adr_rd(oo_adr),
    .ee_tag_in(ee_tg), .eo_tag_in(eo_tg), .oe_tag_in(oe_tg), .oo_tag_in(oo_tg),
    .tc_flush(tc_flush), .tc_busy(tc_busy), .mc_req(mc_req), .mc_bank(mc_bank), .mc_idx(mc_idx),
    .mc_tag(mc_tag), .mc_ack(mc_ack), .mc_done(mc_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_clip(out_clip), .out_miss(out_miss), .ovf_err(ovf_err), .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  initial de_clk = 1'b0;
  always #5 de_clk = ~de_clk;

  // Behavioural cache model and per-cycle expectations.
  bit            m_valid [4][32];
  logic [TW-1:0] m_tag   [4][32];
  bit            m_pend, m_ovf;
  int            m_hit, m_miss;

  bit            chk_en;
  bit            e_busy, e_req, e_ov, e_clip;
  logic [1:0]    e_bank;
  logic [4:0]    e_idx;
  logic [TW-1:0] e_tag;
  logic [3:0]    e_miss;

  int checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Compare process: all outputs checked mid-cycle against the model.
  always @(negedge de_clk) begin
    if (chk_en) begin
      check("tc_busy", 32'(tc_busy), 32'(e_busy));
      check("mc_req", 32'(mc_req), 32'(e_req));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef DE3D_TC_STATS_EN
      check("stat_hit", 32'(stat_hit), 32'(sat16(m_hit)));
      check("stat_miss", 32'(stat_miss), 32'(sat16(m_miss)));
`else
      check("stat_hit", 32'(stat_hit), 32'd0);
      check("stat_miss", 32'(stat_miss), 32'd0);
`endif
      if (e_req) begin
        check("mc_bank", 32'(mc_bank), 32'(e_bank));
        check("mc_idx", 32'(mc_idx), 32'(e_idx));
        check("mc_tag", 32'(mc_tag), 32'(e_tag));
      end
      if (e_ov) begin
        check("out_miss", 32'(out_miss), 32'(e_miss));
        check("out_clip", 32'(out_clip), 32'(e_clip));
      end
    end
  end

  task automatic tick();
    @(posedge de_clk);
    #1;
  endtask

  task automatic set_idle();
    e_busy = 0; e_req = 0; e_ov = 0;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 32; i++) m_valid[b][i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_pend = 0; m_ovf = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic rand_req_data();
    ee_adr = 5'($urandom); eo_adr = 5'($urandom); oe_adr = 5'($urandom); oo_adr = 5'($urandom);
    ee_tg = TW'($urandom); eo_tg = TW'($urandom); oe_tg = TW'($urandom); oo_tg = TW'($urandom);
  endtask

  // One idle cycle, optionally with a flush strobe.
  task automatic idle_cycle(input bit fl);
    set_idle();
    tc_flush = fl;
    tick();
    if (fl || m_pend) model_clear();
    m_pend = 0;
    tc_flush = 0;
  endtask

  // One full lookup from the push cycle through the downstream handshake.
  task automatic txn(input logic [3:0][4:0] ix, input logic [3:0][TW-1:0] tg, input bit clip,
                     input bit do_ovf, input bit do_flush, input bit do_rst,
                     output logic [3:0] got_miss, output logic got_clip, output int nfill,
                     output logic [7:0] order, output logic [4:0] last_idx);
    logic [3:0] emiss;
    bit         first;
    int         d;
    got_miss = '0; got_clip = 0; nfill = 0; order = '0; last_idx = '0; first = 1;

    set_idle();
    push_uv_dd = 1; current_clip_dd = clip;
    ee_adr = ix[0]; eo_adr = ix[1]; oe_adr = ix[2]; oo_adr = ix[3];
    ee_tg = tg[0]; eo_tg = tg[1]; oe_tg = tg[2]; oo_tg = tg[3];
    tick();
    push_uv_dd = 0; current_clip_dd = 0;

    for (int b = 0; b < 4; b++)
      emiss[b] = !clip && !(m_valid[b][ix[b]] && m_tag[b][ix[b]] == tg[b]);

    e_busy = 1;
    if (emiss == '0) begin
      if (do_ovf) begin push_uv_dd = 1; rand_req_data(); end
      if (do_flush) tc_flush = 1;
    end
    tick();
    if (push_uv_dd) m_ovf = 1;
    if (tc_flush) m_pend = 1;
    push_uv_dd = 0; tc_flush = 0;
    if (!clip) begin
      m_hit  += 4 - $countones(emiss);
      m_miss += $countones(emiss);
    end

    for (int b = 0; b < 4; b++) begin
      if (emiss[b]) begin
        d = $urandom_range(0, 2);
        for (int k = 0; k <= d; k++) begin
          e_req = 1; e_bank = 2'(b); e_idx = ix[b]; e_tag = tg[b];
          mc_ack = (k == d);
          if (do_flush && first && k == 0) tc_flush = 1;
          if (k == d) begin
            order = {order[5:0], mc_bank};
            last_idx = mc_idx;
            nfill++;
          end
          tick();
          if (tc_flush) m_pend = 1;
          tc_flush = 0; mc_ack = 0;
        end
        e_req = 0;
        d = $urandom_range(0, 2);
        for (int k = 0; k <= d; k++) begin
          mc_done = (k == d);
          if (first && k == 0 && do_ovf) begin push_uv_dd = 1; rand_req_data(); end
          if (first && k == 0 && do_rst) begin de_rst = 1; mc_done = 0; end
          tick();
          if (push_uv_dd) m_ovf = 1;
          push_uv_dd = 0;
          if (de_rst) begin
            de_rst = 0;
            model_reset();
            set_idle();
            mc_done = 1;  // late completion from before the reset must be ignored
            tick();
            mc_done = 0;
            return;
          end
          if (mc_done) begin
            m_valid[b][ix[b]] = 1;
            m_tag[b][ix[b]]   = tg[b];
          end
          mc_done = 0;
        end
        first = 0;
      end
    end

    d = $urandom_range(0, 2);
    for (int k = 0; k <= d; k++) begin
      e_ov = 1; e_miss = emiss; e_clip = clip;
      if (k == 0) begin got_miss = out_miss; got_clip = out_clip; end
      out_ready = (k == d);
      tick();
      out_ready = 0;
    end
    set_idle();
  endtask

  logic [3:0][4:0]    ixv;
  logic [3:0][TW-1:0] tgv;
  logic [3:0]         gm;
  logic               gc;
  int                 nf;
  logic [7:0]         ord;
  logic [4:0]         lidx;

  initial begin
    checks = 0; errors = 0; chk_en = 0;
    push_uv_dd = 0; current_clip_dd = 0; tc_flush = 0; mc_ack = 0; mc_done = 0; out_ready = 0;
    ee_adr = 0; eo_adr = 0; oe_adr = 0; oo_adr = 0; ee_tg = 0; eo_tg = 0; oe_tg = 0; oo_tg = 0;
    de_rst = 1;
    tick(); tick();
    de_rst = 0;
    model_reset();
    set_idle();
    chk_en = 1;

    // Reset state.
    check("rst_busy", 32'(tc_busy), 0);
    check("rst_mc_req", 32'(mc_req), 0);
    check("rst_mc_bank", 32'(mc_bank), 0);
    check("rst_mc_idx", 32'(mc_idx), 0);
    check("rst_mc_tag", 32'(mc_tag), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_miss", 32'(out_miss), 0);
    check("rst_out_clip", 32'(out_clip), 0);
    check("rst_ovf", 32'(ovf_err), 0);

    // Cold request: every bank misses, fills in bank order.
    ixv = {4{5'd3}}; tgv = {4{13'h055}};
    txn(ixv, tgv, 0, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("cold_miss", 32'(gm), 32'hF);
    check("cold_nfill", 32'(nf), 4);
    check("cold_order", 32'(ord), 32'h1B);

    // Same request again: all hit, no fills.
    txn(ixv, tgv, 0, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("hit_miss", 32'(gm), 0);
    check("hit_nfill", 32'(nf), 0);

    // Clipped request over empty entries.
    txn({4{5'd7}}, tgv, 1, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("clip_flag", 32'(gc), 1);
    check("clip_miss", 32'(gm), 0);
    check("clip_nfill", 32'(nf), 0);

    // Only the eo tag differs: single eo fill at index 3.
    tgv[1] = 13'h0AA;
    txn(ixv, tgv, 0, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("eo_miss", 32'(gm), 32'h2);
    check("eo_nfill", 32'(nf), 1);
    check("eo_bank", 32'(ord), 32'h01);
    check("eo_idx", 32'(lidx), 3);

    // Push during FILL is dropped and flagged.
    txn({4{5'd9}}, {4{13'h055}}, 0, 1, 0, 0, gm, gc, nf, ord, lidx);
    check("ovf_set", 32'(ovf_err), 1);
    check("ovf_miss", 32'(gm), 32'hF);

    // Flush during REQ, applied on the next idle cycle; previous hit now misses.
    txn({4{5'd10}}, {4{13'h055}}, 0, 0, 1, 0, gm, gc, nf, ord, lidx);
    idle_cycle(0);
    txn(ixv, tgv, 0, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("flush_miss", 32'(gm), 32'hF);

    // Reset during FILL.
    txn({4{5'd4}}, {4{13'h011}}, 0, 0, 0, 1, gm, gc, nf, ord, lidx);
    check("rstfill_req", 32'(mc_req), 0);
    check("rstfill_busy", 32'(tc_busy), 0);
    check("rstfill_ovf", 32'(ovf_err), 0);
    txn(ixv, tgv, 0, 0, 0, 0, gm, gc, nf, ord, lidx);
    check("rstfill_miss", 32'(gm), 32'hF);

    // Randomized traffic over a small index/tag space so hits are common.
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < 4; b++) begin
        ixv[b] = 5'($urandom_range(0, 3));
        tgv[b] = TW'($urandom_range(0, 2));
      end
      txn(ixv, tgv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0), gm, gc, nf, ord, lidx);
      if ($urandom_range(0, 1) == 1) idle_cycle($urandom_range(0, 4) == 0);
    end

    idle_cycle(0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
